pyth_leg_solver: RTL and testbench
==================================

Name: pyth_leg_solver

Overview:
- Inverse companion to the hypotenuse-magnitude block.
- Given hypotenuse r and one leg x, computes the other leg y = floor(sqrt(r^2 - x^2)).
- Fully iterative and multiplier-free: shift-add squaring, then a digit-by-digit square root.
- Sits behind the same 8-bit ui_in/uio_in style operand buses, with a start/busy/done handshake.

Parameters:
- W, 8, operand and result width; internal squares and radicand are 2W bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  clock enable; when low, all state, including counters and outputs, holds.
- start  input  1  request; sampled only in IDLE with ena high.
- hyp_in  input  W  hypotenuse r (unsigned).
- leg_in  input  W  known leg x (unsigned).
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a result is valid.
- leg_out  output  W  result y; holds until the next done.
- invalid  output  1  set with done when x > r; holds with leg_out.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; busy=0, done=0, leg_out=0, invalid=0.
  - All internal registers cleared.
  - Reset mid-operation aborts immediately; no done is produced.
- States: IDLE, SQ_H, SQ_L, DIFF, ROOT, DONE. Step counter is log2(W)+1 bits.
- IDLE:
  - On edge E0 with start=1 and ena=1: latch hyp_in/leg_in, clear accumulator and counter, go to SQ_H.
  - start in any other state is ignored.
- SQ_H, edges E1..EW:
  - One shift-add step per edge, LSB first: if the current multiplier bit is 1, acc += r << i.
  - After W steps, r2 = r*r (2W bits, no overflow); go to SQ_L.
- SQ_L, edges E(W+1)..E(2W): same procedure for x2 = x*x; go to DIFF.
- DIFF, edge E(2W+1):
  - If x > r: leg_out=0, invalid=1, done=1, go to DONE. ROOT is skipped, so done is high after E(2W+1).
  - Else: radicand = r2 - x2 (never negative), rem=0, root=0; go to ROOT.
- ROOT, edges E(2W+2)..E(3W+1):
  - One restoring digit step per edge, consuming 2 radicand bits MSB first.
  - trial = (rem<<2 | next two bits) - (root<<2 | 1). If trial >= 0: rem = trial, root = root<<1 | 1. Else: rem shifts in the bits, root = root<<1.
  - After W steps, leg_out = root (floor sqrt, fits W bits since radicand < 2^(2W)), invalid=0, done=1, go to DONE.
- DONE:
  - done high for exactly this one cycle; the next enabled edge clears done and returns to IDLE.
- Latency from accept edge E0: valid path done high after E(3W+1), i.e. 25 clocks for W=8; invalid path after E(2W+1), i.e. 17 clocks.
- Throughput: a new start is accepted no earlier than the cycle after DONE.
- ena low in any state freezes everything, including the done pulse, which stretches until ena returns; the latency count is in enabled edges.
- x == r gives leg_out=0, invalid=0. Wide operands: r=x=2^W-1 gives 0.

Test Plan:
- Reset then start r=5, x=3 -> busy high for 25 clocks; done pulse with leg_out=4, invalid=0; busy low the next cycle.
- r=10, x=7 (radicand 51) -> leg_out=7 (floor); r=255, x=0 -> leg_out=255; r=0, x=0 -> leg_out=0.
- r=3, x=5 -> done after 17 clocks with leg_out=0, invalid=1; a following r=13, x=5 -> leg_out=12, invalid cleared.
- Pulse start again mid-computation with r=200, x=1 -> ignored; the original result is delivered and no second done occurs.
- Drop ena for 5 cycles during ROOT -> done arrives exactly 5 clocks late with the correct value; done is held while ena is low in DONE.
- Assert rst_n low during SQ_L -> all outputs 0 immediately, IDLE; a subsequent start r=255, x=255 -> leg_out=0, invalid=0.

Source files
------------

// File: rtl/pyth_leg_solver.sv
// pyth_leg_solver: iterative, multiplier-free y = floor(sqrt(r^2 - x^2)) with start/busy/done handshake
//   clk, rst_n (async active-low), ena (global clock enable)
//   start, hyp_in (r), leg_in (x)  -> request and operands, accepted only in IDLE
//   busy, done (one-cycle pulse), leg_out (result y), invalid (x > r)
module pyth_leg_solver #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic         start,
  input  logic [W-1:0] hyp_in,
  input  logic [W-1:0] leg_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] leg_out,
  output logic         invalid
);
  localparam int CW = $clog2(W) + 1;
  typedef enum logic [2:0] {IDLE, SQ_H, SQ_L, DIFF, ROOT, DONE} state_t;
  state_t state, state_nxt;
  logic [W-1:0]   r, x, root, m, root_nxt;
  logic [2*W-1:0] acc, r2, rad, term, sum;
  logic [W+3:0]   rem, cand, test, rem_nxt;
  logic [CW-1:0]  cnt;
  logic           last, ge;
  // shared shift-add squarer: the operand being squared is also its own multiplier
  assign m    = state == SQ_H ? r : x;
  assign last = cnt == CW'(W - 1);
  assign term = m[cnt[CW-2:0]] ? ({{W{1'b0}}, m} << cnt) : '0;
  assign sum  = acc + term;
  // restoring square-root digit: bring down two radicand bits, try subtracting 4*root+1
  assign cand     = {rem[W+1:0], rad[2*W-1 -: 2]};
  assign test     = {2'b00, root, 2'b01};
  assign ge       = cand >= test;
  assign rem_nxt  = ge ? cand - test : cand;
  assign root_nxt = {root[W-2:0], ge};
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else if (ena) state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? SQ_H : IDLE;
      SQ_H:    state_nxt = last ? SQ_L : SQ_H;
      SQ_L:    state_nxt = last ? DIFF : SQ_L;
      DIFF:    state_nxt = x > r ? DONE : ROOT;
      ROOT:    state_nxt = last ? DONE : ROOT;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r       <= '0;
      x       <= '0;
      acc     <= '0;
      r2      <= '0;
      rad     <= '0;
      rem     <= '0;
      root    <= '0;
      cnt     <= '0;
      leg_out <= '0;
      invalid <= 1'b0;
    end else if (ena) begin
      case (state)
        IDLE: if (start) begin
          r   <= hyp_in;
          x   <= leg_in;
          acc <= '0;
          cnt <= '0;
        end
        SQ_H: begin
          acc <= last ? '0 : sum;
          r2  <= last ? sum : r2;
          cnt <= last ? '0 : cnt + 1'b1;
        end
        SQ_L: begin
          acc <= sum;
          cnt <= last ? '0 : cnt + 1'b1;
        end
        DIFF: if (x > r) begin
          leg_out <= '0;
          invalid <= 1'b1;
        end else begin
          rad  <= r2 - acc;
          rem  <= '0;
          root <= '0;
          cnt  <= '0;
        end
        ROOT: begin
          rad  <= rad << 2;
          rem  <= rem_nxt;
          root <= root_nxt;
          cnt  <= cnt + 1'b1;
          if (last) begin
            leg_out <= root_nxt;
            invalid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pyth_leg_solver.sv
// tb_pyth_leg_solver: randomized and directed self-checking bench for pyth_leg_solver
module tb_pyth_leg_solver;
  logic       clk = 0, rst_n = 0, ena = 1, start = 0;
  logic [7:0] hyp_in = 0, leg_in = 0;
  logic       busy, done, invalid;
  logic [7:0] leg_out;
  int checks = 0, errors = 0;

  pyth_leg_solver #(.W(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .hyp_in(hyp_in), .leg_in(leg_in),
    .busy(busy), .done(done), .leg_out(leg_out), .invalid(invalid)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int model_leg(input int r, input int x);
    int d, y;
    if (x > r) return 0;
    d = r * r - x * x;
    y = 0;
    while ((y + 1) * (y + 1) <= d) y++;
    return y;
  endfunction

  // waits for idle, issues a request, returns the number of enabled edges until done
  task automatic run(input int r, input int x, output int cyc);
    int g = 0;
    while (busy && g < 100) begin tick; g++; end
    hyp_in = 8'(r);
    leg_in = 8'(x);
    start  = 1;
    tick;
    start = 0;
    cyc = 0;
    while (!done && cyc < 100) begin tick; cyc++; end
  endtask

  task automatic test_reset;
    checks++;
    if ({busy, done, invalid, leg_out} !== 11'd0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b invalid=%b leg_out=%0d, want all 0", busy, done, invalid, leg_out);
    end
  endtask

  task automatic test_basic;
    int cyc;
    run(5, 3, cyc);
    checks++;
    if (cyc !== 25 || leg_out !== 8'd4 || invalid !== 1'b0) begin
      errors++;
      $display("FAIL basic_5_3: cyc=%0d leg=%0d inv=%b, want 25/4/0", cyc, leg_out, invalid);
    end
    tick;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL basic_after: busy=%b done=%b, want 0/0", busy, done);
    end
  endtask

  task automatic test_vectors;
    int rv[6] = '{10, 255, 0, 13, 255, 100};
    int xv[6] = '{7, 0, 0, 5, 255, 100};
    int cyc, exp;
    for (int i = 0; i < 6; i++) begin
      run(rv[i], xv[i], cyc);
      exp = model_leg(rv[i], xv[i]);
      checks++;
      if (cyc !== 25 || leg_out !== 8'(exp) || invalid !== 1'b0) begin
        errors++;
        $display("FAIL vector r=%0d x=%0d: cyc=%0d leg=%0d inv=%b, want 25/%0d/0", rv[i], xv[i], cyc, leg_out, invalid, exp);
      end
    end
  endtask

  task automatic test_invalid;
    int cyc;
    run(3, 5, cyc);
    checks++;
    if (cyc !== 17 || leg_out !== 8'd0 || invalid !== 1'b1) begin
      errors++;
      $display("FAIL invalid_3_5: cyc=%0d leg=%0d inv=%b, want 17/0/1", cyc, leg_out, invalid);
    end
    run(13, 5, cyc);
    checks++;
    if (cyc !== 25 || leg_out !== 8'd12 || invalid !== 1'b0) begin
      errors++;
      $display("FAIL invalid_clear: cyc=%0d leg=%0d inv=%b, want 25/12/0", cyc, leg_out, invalid);
    end
  endtask

  task automatic test_ignore_start;
    int cyc = 0, extra = 0;
    while (busy && cyc < 100) begin tick; cyc++; end
    hyp_in = 5; leg_in = 3; start = 1;
    tick;
    start = 0;
    repeat (5) tick;
    hyp_in = 200; leg_in = 1; start = 1;
    tick;
    start = 0;
    cyc = 6;
    while (!done && cyc < 100) begin tick; cyc++; end
    checks++;
    if (cyc !== 25 || leg_out !== 8'd4) begin
      errors++;
      $display("FAIL ignore_start: cyc=%0d leg=%0d, want 25/4", cyc, leg_out);
    end
    tick;
    repeat (40) begin
      if (done) extra++;
      tick;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL ignore_start_second_done: done cycles=%0d, want 0", extra);
    end
  endtask

  task automatic test_ena_stall;
    int cyc = 0, g = 0;
    while (busy && g < 100) begin tick; g++; end
    hyp_in = 13; leg_in = 5; start = 1;
    tick;
    start = 0;
    while (!done && cyc < 100) begin
      tick;
      cyc++;
      ena = !(cyc >= 20 && cyc < 25);
    end
    ena = 1;
    checks++;
    if (cyc !== 30 || leg_out !== 8'd12) begin
      errors++;
      $display("FAIL ena_stall: cyc=%0d leg=%0d, want 30/12", cyc, leg_out);
    end
    ena = 0;
    repeat (3) begin
      tick;
      checks++;
      if (done !== 1'b1 || leg_out !== 8'd12) begin
        errors++;
        $display("FAIL ena_hold_done: done=%b leg=%0d, want 1/12", done, leg_out);
      end
    end
    ena = 1;
    tick;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ena_release: done=%b busy=%b, want 0/0", done, busy);
    end
  endtask

  task automatic test_reset_mid;
    int cyc, ndone = 0;
    hyp_in = 255; leg_in = 200; start = 1;
    tick;
    start = 0;
    repeat (12) tick;
    rst_n = 0;
    #1;
    checks++;
    if ({busy, done, invalid, leg_out} !== 11'd0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b inv=%b leg=%0d, want all 0", busy, done, invalid, leg_out);
    end
    rst_n = 1;
    repeat (30) begin
      tick;
      if (done) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errors++;
      $display("FAIL reset_mid_no_done: done cycles=%0d, want 0", ndone);
    end
    run(255, 255, cyc);
    checks++;
    if (cyc !== 25 || leg_out !== 8'd0 || invalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_next: cyc=%0d leg=%0d inv=%b, want 25/0/0", cyc, leg_out, invalid);
    end
  endtask

  task automatic test_random;
    int r, x, cyc, exp;
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(255);
      x = (i % 4 == 0) ? $urandom_range(255) : $urandom_range(r);
      run(r, x, cyc);
      exp = model_leg(r, x);
      checks++;
      if (cyc !== (x > r ? 17 : 25) || leg_out !== 8'(exp) || invalid !== (x > r)) begin
        errors++;
        $display("FAIL random r=%0d x=%0d: cyc=%0d leg=%0d inv=%b, want %0d/%0d/%b", r, x, cyc, leg_out, invalid, x > r ? 17 : 25, exp, x > r);
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    rst_n = 1;
    tick;
    test_basic;
    test_vectors;
    test_invalid;
    test_ignore_start;
    test_ena_stall;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
